// File: rtl/nf_rf_pkg.sv
// ---------------------------------------------------------------------------
// nf_rf_pkg
// Shared types and helpers for the decode-stage register file with
// pending-write scoreboard (nf_reg_file_sb).
//   rf_state_t  : clear-sweep / running state of the register file
//   NF_XLEN_DEF : default datapath width
//   rf_aw()     : address width for a given register count
// ---------------------------------------------------------------------------
package nf_rf_pkg;

   typedef enum logic [0:0] {
      RF_INIT = 1'b0,
      RF_RUN  = 1'b1
   } rf_state_t;

   localparam int NF_XLEN_DEF = 32;

   function automatic int rf_aw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nf_rf_scoreboard.sv
// ---------------------------------------------------------------------------
// nf_rf_scoreboard
// One pending-write bit per register. Issue marks a destination, writeback
// clears it. A mark and a clear of the same register in one cycle leave the
// bit set, because the mark belongs to the newer producer. Bit 0 never sets.
// Ports:
//   clk, rst             clock, asynchronous active-high reset (clears all)
//   clr                  synchronous clear of the whole vector
//   set_en / set_addr    mark a register pending
//   clr0_en / clr0_addr  writeback port 0 clear
//   clr1_en / clr1_addr  writeback port 1 clear
//   sb                   scoreboard bit vector
// ---------------------------------------------------------------------------
module nf_rf_scoreboard
   import nf_rf_pkg::*;
#(
   parameter int REG_NUM = 32,
   parameter int AW      = rf_aw(REG_NUM)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               set_en,
   input  logic [AW-1:0]      set_addr,
   input  logic               clr0_en,
   input  logic [AW-1:0]      clr0_addr,
   input  logic               clr1_en,
   input  logic [AW-1:0]      clr1_addr,
   output logic [REG_NUM-1:0] sb
);

   logic [REG_NUM-1:0] sb_n;

   always_comb begin
      sb_n = sb;
      for (int i = 1; i < REG_NUM; i++) begin
         if ((clr0_en && clr0_addr == AW'(i)) || (clr1_en && clr1_addr == AW'(i)))
            sb_n[i] = 1'b0;
         // Applied after the clear so a same-cycle mark wins.
         if (set_en && set_addr == AW'(i))
            sb_n[i] = 1'b1;
      end
      sb_n[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sb <= '0;
      else if (clr)
         sb <= '0;
      else
         sb <= sb_n;
   end

endmodule

// File: rtl/nf_reg_file_sb.sv
// ---------------------------------------------------------------------------
// nf_reg_file_sb
// Register file with two write ports (port 0 = ALU writeback, higher
// priority; port 1 = load writeback), RD_PORTS combinational read ports with
// same-cycle write forwarding, a pending-write scoreboard and a post-reset
// clear sweep. Register 0 reads as zero and is never marked busy.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   init_done             high once the clear sweep has finished
//   ra / rd / rbusy       read addresses, forwarded data, busy flags (port k
//                         at [k*AW +: AW], [k*XLEN +: XLEN], [k])
//   wa0/wd0/we0           write port 0
//   wa1/wd1/we1           write port 1
//   mark_en / mark_addr   mark an issued destination pending
//   ra_dbg/rd_dbg/sb_dbg  register viewer ports, present only when
//                         NF_RF_DEBUG_EN is defined
// ---------------------------------------------------------------------------
module nf_reg_file_sb
   import nf_rf_pkg::*;
#(
   parameter int XLEN     = NF_XLEN_DEF,
   parameter int REG_NUM  = 32,
   parameter int RD_PORTS = 2,
   localparam int AW      = rf_aw(REG_NUM)
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     init_done,
   input  logic [RD_PORTS*AW-1:0]   ra,
   output logic [RD_PORTS*XLEN-1:0] rd,
   output logic [RD_PORTS-1:0]      rbusy,
   input  logic [AW-1:0]            wa0,
   input  logic [XLEN-1:0]          wd0,
   input  logic                     we0,
   input  logic [AW-1:0]            wa1,
   input  logic [XLEN-1:0]          wd1,
   input  logic                     we1,
`ifdef NF_RF_DEBUG_EN
   input  logic [AW-1:0]            ra_dbg,
   output logic [XLEN-1:0]          rd_dbg,
   output logic [REG_NUM-1:0]       sb_dbg,
`endif
   input  logic                     mark_en,
   input  logic [AW-1:0]            mark_addr
);

   rf_state_t          state, state_n;
   logic [AW-1:0]      cnt, cnt_n;
   logic               run;
   logic [REG_NUM-1:0] sb;
   logic [XLEN-1:0]    mem [REG_NUM];

   assign run       = (state == RF_RUN);
   assign init_done = run;

   // Sweep control: counter walks 1..REG_NUM-1, then the file goes live.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RF_INIT;
         cnt   <= AW'(1);
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         RF_INIT: begin
            cnt_n = cnt + AW'(1);
            if (cnt == AW'(REG_NUM - 1))
               state_n = RF_RUN;
         end
         RF_RUN:  state_n = RF_RUN;
         default: state_n = RF_INIT;
      endcase
   end

   // Storage has no reset; the sweep zeroes it. Port 0 is written last so
   // it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (!run) begin
         mem[cnt] <= '0;
      end else begin
         if (we1 && wa1 != '0)
            mem[wa1] <= wd1;
         if (we0 && wa0 != '0)
            mem[wa0] <= wd0;
      end
   end

   nf_rf_scoreboard #(
      .REG_NUM (REG_NUM),
      .AW      (AW)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .clr       (!run),
      .set_en    (mark_en && run),
      .set_addr  (mark_addr),
      .clr0_en   (we0 && run),
      .clr0_addr (wa0),
      .clr1_en   (we1 && run),
      .clr1_addr (wa1),
      .sb        (sb)
   );

   function automatic logic [XLEN-1:0] fwd_data(
      input logic [AW-1:0]   a,
      input logic [XLEN-1:0] stored,
      input logic            w0,
      input logic [AW-1:0]   a0,
      input logic [XLEN-1:0] d0,
      input logic            w1,
      input logic [AW-1:0]   a1,
      input logic [XLEN-1:0] d1
   );
      if (a == '0)
         return '0;
      else if (w0 && a0 == a)
         return d0;
      else if (w1 && a1 == a)
         return d1;
      else
         return stored;
   endfunction

   function automatic logic wr_hit(
      input logic [AW-1:0] a,
      input logic          w0,
      input logic [AW-1:0] a0,
      input logic          w1,
      input logic [AW-1:0] a1
   );
      return (w0 && a0 == a) || (w1 && a1 == a);
   endfunction

   for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
      logic [AW-1:0] a;
      assign a = ra[k*AW +: AW];
      assign rd[k*XLEN +: XLEN] = run ? fwd_data(a, mem[a], we0, wa0, wd0, we1, wa1, wd1) : '0;
      // Data being forwarded this cycle is already available, so not busy.
      assign rbusy[k] = run && sb[a] && !wr_hit(a, we0, wa0, we1, wa1);
   end

`ifdef NF_RF_DEBUG_EN
   assign rd_dbg = run ? fwd_data(ra_dbg, mem[ra_dbg], we0, wa0, wd0, we1, wa1, wd1) : '0;
   assign sb_dbg = sb;
`endif

endmodule

// File: tb/tb_nf_reg_file_sb.sv
module tb_nf_reg_file_sb;

   localparam int XLEN     = 32;
   localparam int REG_NUM  = 32;
   localparam int RD_PORTS = 2;
   localparam int AW       = 5;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     init_done;
   logic [RD_PORTS*AW-1:0]   ra;
   logic [RD_PORTS*XLEN-1:0] rd;
   logic [RD_PORTS-1:0]      rbusy;
   logic [AW-1:0]            wa0, wa1, mark_addr;
   logic [XLEN-1:0]          wd0, wd1;
   logic                     we0, we1, mark_en;

   int checks   = 0;
   int failures = 0;

   nf_reg_file_sb #(
      .XLEN     (XLEN),
      .REG_NUM  (REG_NUM),
      .RD_PORTS (RD_PORTS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .init_done (init_done),
      .ra        (ra),
      .rd        (rd),
      .rbusy     (rbusy),
      .wa0       (wa0),
      .wd0       (wd0),
      .we0       (we0),
      .wa1       (wa1),
      .wd1       (wd1),
      .we1       (we1),
      .mark_en   (mark_en),
      .mark_addr (mark_addr)
   );

   always #5 clk = ~clk;

   // Reference model: architectural register values and pending set.
   logic [XLEN-1:0] m_mem [REG_NUM];
   bit              m_sb  [REG_NUM];
   bit              m_run;
   int              m_left;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
      if (!m_run || a == 0) return '0;
      if (we0 && wa0 == a) return wd0;
      if (we1 && wa1 == a) return wd1;
      return m_mem[a];
   endfunction

   function automatic logic m_busy(input logic [AW-1:0] a);
      if (!m_run || a == 0) return 1'b0;
      if ((we0 && wa0 == a) || (we1 && wa1 == a)) return 1'b0;
      return m_sb[a];
   endfunction

   task automatic idle();
      we0 = 0; wa0 = '0; wd0 = '0;
      we1 = 0; wa1 = '0; wd1 = '0;
      mark_en = 0; mark_addr = '0;
      ra = '0;
   endtask

   // Entered at a negedge with inputs applied; leaves at the next negedge.
   task automatic step();
      logic [AW-1:0] a;
      #1;
      check_eq("init_done", init_done, m_run);
      for (int k = 0; k < RD_PORTS; k++) begin
         a = ra[k*AW +: AW];
         check_eq($sformatf("rd%0d_a%0d", k, a), rd[k*XLEN +: XLEN], m_read(a));
         check_eq($sformatf("rbusy%0d_a%0d", k, a), rbusy[k], m_busy(a));
      end
      @(posedge clk);
      if (m_run) begin
         if (we1 && wa1 != 0) m_mem[wa1] = wd1;
         if (we0 && wa0 != 0) m_mem[wa0] = wd0;
         if (we0) m_sb[wa0] = 0;
         if (we1) m_sb[wa1] = 0;
         if (mark_en && mark_addr != 0) m_sb[mark_addr] = 1;
      end else begin
         m_left--;
         if (m_left == 0) m_run = 1;
      end
      @(negedge clk);
   endtask

   // Reset for one cycle; the sweep leaves every register zero and idle.
   task automatic pulse_rst();
      rst = 1'b1;
      #1;
      check_eq("rst_init_done", init_done, 0);
      check_eq("rst_rbusy", rbusy, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_run  = 0;
      m_left = REG_NUM - 1;
      for (int i = 0; i < REG_NUM; i++) begin
         m_mem[i] = '0;
         m_sb[i]  = 0;
      end
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, REG_NUM - 1));
      return AW'($urandom_range(0, 9));
   endfunction

   initial begin
      int n;
      rst = 1'b1;
      idle();
      @(negedge clk);
      pulse_rst();

      // Sweep length, writes/marks ignored and reads zero while sweeping.
      we0 = 1; wa0 = 5; wd0 = 32'hAA; mark_en = 1; mark_addr = 5;
      ra = {AW'(5), AW'(5)};
      n = 0;
      while (!init_done && n < 100) begin
         step();
         n++;
      end
      check_eq("sweep_len", n, REG_NUM - 1);
      idle(); ra[AW-1:0] = 5;
      #1 check_eq("sweep_ignored_wr", rd[XLEN-1:0], 0);
      step();

      // Forwarding.
      we0 = 1; wa0 = 3; wd0 = 32'h1234_5678; ra[AW-1:0] = 3;
      #1 check_eq("fwd_same", rd[XLEN-1:0], 32'h1234_5678);
      step();
      idle(); ra[AW-1:0] = 3;
      #1 check_eq("fwd_stored", rd[XLEN-1:0], 32'h1234_5678);
      step();
      wa0 = 3; we0 = 0; wd0 = 32'hDEAD;
      #1 check_eq("no_fwd", rd[XLEN-1:0], 32'h1234_5678);
      step();

      // Collision.
      idle(); we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h11; wd1 = 32'h22;
      ra[AW-1:0] = 7;
      #1 check_eq("coll_same", rd[XLEN-1:0], 32'h11);
      step();
      idle(); ra[AW-1:0] = 7;
      #1 check_eq("coll_stored", rd[XLEN-1:0], 32'h11);
      step();

      // Scoreboard.
      idle(); mark_en = 1; mark_addr = 9; ra[AW-1:0] = 9;
      #1 check_eq("mark_not_yet", rbusy[0], 0);
      step();
      idle(); ra[AW-1:0] = 9;
      #1 check_eq("mark_busy", rbusy[0], 1);
      step();
      we1 = 1; wa1 = 9; wd1 = 32'h99;
      #1 check_eq("wr_cycle_free", rbusy[0], 0);
      step();
      idle(); ra[AW-1:0] = 9;
      #1 check_eq("wr_after_free", rbusy[0], 0);
      step();
      mark_en = 1; mark_addr = 9; we0 = 1; wa0 = 9; wd0 = 32'h98;
      step();
      idle(); ra[AW-1:0] = 9;
      #1 check_eq("mark_wins", rbusy[0], 1);
      step();

      // Zero register.
      idle(); we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF; mark_en = 1; mark_addr = 0;
      step();
      idle();
      #1 check_eq("zero_rd", rd[XLEN-1:0], 0);
      check_eq("zero_busy", rbusy[0], 0);
      step();

      // Reset mid-run.
      we0 = 1; wa0 = 4; wd0 = 32'h55;
      step();
      idle();
      pulse_rst();
      n = 0;
      while (!init_done && n < 100) begin
         step();
         n++;
      end
      check_eq("rerun_sweep_len", n, REG_NUM - 1);
      ra = {AW'(9), AW'(4)};
      #1 check_eq("rst_reg4", rd[XLEN-1:0], 0);
      check_eq("rst_busy_all", rbusy, 0);
      step();

      // Randomized traffic with rare resets.
      for (int i = 0; i < 1500; i++) begin
         we0 = 1'($urandom_range(0, 1)); wa0 = rnd_addr(); wd0 = $urandom();
         we1 = 1'($urandom_range(0, 1)); wa1 = rnd_addr(); wd1 = $urandom();
         mark_en = 1'($urandom_range(0, 1)); mark_addr = rnd_addr();
         for (int k = 0; k < RD_PORTS; k++) ra[k*AW +: AW] = rnd_addr();
         if ($urandom_range(0, 399) == 0)
            pulse_rst();
         else
            step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
